// File: rtl/alu_rsp_arbiter.sv
// alu_rsp_arbiter
//   Merges commit responses from the PEs of one ALU block (integer unit,
//   mul/div unit) into a single commit stream toward the gather stage.
//   One requester is chosen per packet and keeps the grant until that
//   packet's eop beat is accepted. The output goes through a two-entry
//   registered skid buffer (main + skid), so there is no combinational path
//   from rsp_ready to req_ready.
//
//   Optional feature macro: ALU_RSP_ARB_RR_EN
//     defined   -> round-robin priority. The pointer moves past the granted
//                  requester on every accepted eop beat.
//     undefined -> fixed priority, lowest index wins. No pointer register.
//
//   Handshake: a beat moves across an interface in any cycle where valid and
//   ready are both high on the rising clock edge. A source that raises valid
//   holds valid and payload stable until the transfer. Ready never depends on
//   the valid of the same interface's partner downstream.
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   req_valid/data/sop/eop      per-requester beat (data slice i*DATA_WIDTH)
//   req_ready                   per-requester accept, at most one bit high
//   rsp_valid/data/sop/eop/sel  merged output beat; sel = source index
//   rsp_ready                   downstream accept
//   lock_state is the internal FSM state (open / locked).
module alu_rsp_arbiter #(
  parameter int NUM_REQS   = 2,
  parameter int DATA_WIDTH = 64,
  localparam int SEL_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQS-1:0]            req_sop,
  input  logic [NUM_REQS-1:0]            req_eop,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_sop,
  output logic                           rsp_eop,
  output logic [SEL_W-1:0]               rsp_sel,
  input  logic                           rsp_ready
);

  typedef struct packed {
    logic [SEL_W-1:0]      sel;
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      lock_state_q, lock_state_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             accept;
  logic             main_free;
  beat_t            in_beat;
  beat_t            main_q, skid_q;
  logic             main_valid_q;
  logic             skid_full_q;

`ifdef ALU_RSP_ARB_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Grant selection. While a packet is open the grant stays on its owner,
  // even if that owner drops valid mid-packet.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (lock_state_q == ST_LOCKED) begin
      grant     = lock_idx_q;
      grant_vld = 1'b1;
    end else begin
`ifdef ALU_RSP_ARB_RR_EN
      // Walk backwards so the requester closest to the pointer is written last.
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQS]) begin
          grant     = SEL_W'((int'(rr_ptr_q) + k) % NUM_REQS);
          grant_vld = 1'b1;
        end
      end
`else
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grant     = SEL_W'(i);
          grant_vld = 1'b1;
        end
      end
`endif
    end
  end

  // Ready depends only on registered state and req_valid, never on rsp_ready.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = grant_vld && (grant == SEL_W'(i)) && !skid_full_q;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    in_beat = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant == SEL_W'(i)) begin
        in_beat.data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_beat.sop  = req_sop[i];
        in_beat.eop  = req_eop[i];
      end
    end
    in_beat.sel = grant;
  end

  // Lock FSM next state: a non-eop beat opens the packet, an eop beat closes it.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    if (accept) begin
      if (in_beat.eop) begin
        lock_state_d = ST_OPEN;
      end else begin
        lock_state_d = ST_LOCKED;
        lock_idx_d   = grant;
      end
    end
  end

`ifdef ALU_RSP_ARB_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && in_beat.eop) begin
      rr_ptr_d = (int'(grant) == NUM_REQS - 1) ? '0 : grant + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_state_q <= ST_OPEN;
      lock_idx_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

  // Main register is free when empty or drained this cycle. A beat accepted
  // while main is stuck lands in skid; skid_full then blocks further accepts
  // until skid has moved into main.
  assign main_free = !main_valid_q || rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_full_q  <= 1'b0;
    end else if (main_free) begin
      if (skid_full_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_full_q  <= accept;
        if (accept) skid_q <= in_beat;
      end else begin
        main_valid_q <= accept;
        if (accept) main_q <= in_beat;
      end
    end else if (accept) begin
      skid_q      <= in_beat;
      skid_full_q <= 1'b1;
    end
  end

  assign rsp_valid = main_valid_q;
  assign rsp_data  = main_q.data;
  assign rsp_sop   = main_q.sop;
  assign rsp_eop   = main_q.eop;
  assign rsp_sel   = main_q.sel;

endmodule

// File: tb/tb_alu_rsp_arbiter.sv
// Testbench for alu_rsp_arbiter (two requesters, 64-bit data).
// Requester sources are queues of beats presented with valid/ready; expected
// output beats are pushed to exp_q by each directed step and compared when the
// DUT emits a beat.
module tb_alu_rsp_arbiter;
  localparam int N  = 2;
  localparam int DW = 64;
  localparam int EW = 1 + 2 + DW;  // {sel, sop, eop, data}
  localparam int BW = 2 + DW;      // {sop, eop, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_sop;
  logic [N-1:0]    req_eop;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_sop;
  logic            rsp_eop;
  logic [0:0]      rsp_sel;
  logic            rsp_ready;

  alu_rsp_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_sop   (req_sop),
    .req_eop   (req_eop),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_sop   (rsp_sop),
    .rsp_eop   (rsp_eop),
    .rsp_sel   (rsp_sel),
    .rsp_ready (rsp_ready)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] src0_q[$];
  logic [BW-1:0] src1_q[$];
  logic          gap0 = 1'b0;
  logic          gap1 = 1'b0;
  logic [N-1:0]  rdy_s;
  logic          rv_s;
  logic [DW-1:0] rd_s;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void src(input int r, input logic sop, input logic eop, input logic [DW-1:0] d);
    if (r == 0) src0_q.push_back({sop, eop, d});
    else        src1_q.push_back({sop, eop, d});
  endfunction

  function automatic void expect_beat(input logic sel, input logic sop, input logic eop,
                                      input logic [DW-1:0] d);
    exp_q.push_back({sel, sop, eop, d});
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: drive at negedge, sample/compare 1ns later, then pop
  // accepted beats after the rising edge.
  task automatic tick();
    logic [N-1:0]  acc;
    logic [EW-1:0] e;
    @(negedge clk);
    req_valid[0] = (src0_q.size() > 0) && !gap0;
    req_valid[1] = (src1_q.size() > 0) && !gap1;
    if (src0_q.size() > 0) {req_sop[0], req_eop[0], req_data[0 +: DW]} = src0_q[0];
    else                   {req_sop[0], req_eop[0], req_data[0 +: DW]} = '0;
    if (src1_q.size() > 0) {req_sop[1], req_eop[1], req_data[DW +: DW]} = src1_q[0];
    else                   {req_sop[1], req_eop[1], req_data[DW +: DW]} = '0;
    #1;
    rdy_s = req_ready;
    rv_s  = rsp_valid;
    rd_s  = rsp_data;
    check("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
    acc = req_valid & req_ready;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {rsp_sel, rsp_sop, rsp_eop, rsp_data}, '0);
      end else begin
        e = exp_q.pop_front();
        check("beat", {rsp_sel, rsp_sop, rsp_eop, rsp_data}, e);
      end
    end
    @(posedge clk);
    #1;
    if (acc[0]) void'(src0_q.pop_front());
    if (acc[1]) void'(src1_q.pop_front());
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_sop   = '0;
    req_eop   = '0;
    gap0      = 1'b0;
    gap1      = 1'b0;
    exp_q.delete();
    src0_q.delete();
    src1_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_q.size() + src0_q.size() + src1_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rsp_ready = 1'b1;
    do_reset();

    // Reset state and first beat latency
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_sel", rsp_sel, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_flags", {rsp_sop, rsp_eop}, 2'b00);
    check("rst_req_ready_idle", req_ready, 2'b00);
    src(0, 1'b1, 1'b1, 64'hA5);
    expect_beat(1'b0, 1'b1, 1'b1, 64'hA5);
    tick();
    check("t1_ready", rdy_s, 2'b01);
    check("t1_not_yet_valid", rv_s, 1'b0);
    tick();
    check("t1_valid_next", rv_s, 1'b1);
    check("t1_data", rd_s, 64'hA5);
    drain("t1_drain", 5);

    // Contention with single-beat packets
    do_reset();
    for (int k = 0; k < 6; k++) begin
      src(0, 1'b1, 1'b1, 64'h20 + 64'(k));
      src(1, 1'b1, 1'b1, 64'h30 + 64'(k));
    end
`ifdef ALU_RSP_ARB_RR_EN
    for (int k = 0; k < 6; k++) begin
      expect_beat(1'b0, 1'b1, 1'b1, 64'h20 + 64'(k));
      expect_beat(1'b1, 1'b1, 1'b1, 64'h30 + 64'(k));
    end
`else
    for (int k = 0; k < 6; k++) expect_beat(1'b0, 1'b1, 1'b1, 64'h20 + 64'(k));
    for (int k = 0; k < 6; k++) expect_beat(1'b1, 1'b1, 1'b1, 64'h30 + 64'(k));
`endif
    drain("t2_drain", 40);

    // Packet lock with a valid gap on the owner
    do_reset();
    src(1, 1'b1, 1'b0, 64'h10);
    src(1, 1'b0, 1'b0, 64'h11);
    src(1, 1'b0, 1'b1, 64'h12);
    expect_beat(1'b1, 1'b1, 1'b0, 64'h10);
    expect_beat(1'b1, 1'b0, 1'b0, 64'h11);
    expect_beat(1'b1, 1'b0, 1'b1, 64'h12);
    for (int k = 0; k < 4; k++) expect_beat(1'b0, 1'b1, 1'b1, 64'h40 + 64'(k));
    tick();
    check("t3_first_grant", rdy_s, 2'b10);
    for (int k = 0; k < 4; k++) src(0, 1'b1, 1'b1, 64'h40 + 64'(k));
    gap1 = 1'b1;
    tick();
    check("t3_gap_hold", rdy_s, 2'b10);
    gap1 = 1'b0;
    tick();
    check("t3_mid_hold", rdy_s, 2'b10);
    drain("t3_drain", 20);

    // Backpressure through the skid register
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      src(0, 1'b1, 1'b1, 64'(k));
      expect_beat(1'b0, 1'b1, 1'b1, 64'(k));
    end
    repeat (3) tick();
    rsp_ready = 1'b0;
    tick();
    check("t4_skid_accept", rdy_s, 2'b01);
    tick();
    check("t4_stall_ready_b", rdy_s, 2'b00);
    check("t4_hold_data_b", rd_s, 64'd3);
    tick();
    check("t4_stall_ready_c", rdy_s, 2'b00);
    check("t4_hold_data_c", rd_s, 64'd3);
    rsp_ready = 1'b1;
    tick();
    check("t4_skid_drain_ready", rdy_s, 2'b00);
    check("t4_drain_data", rd_s, 64'd3);
    tick();
    check("t4_resume_ready", rdy_s, 2'b01);
    check("t4_skid_beat", rd_s, 64'd4);
    drain("t4_drain", 20);

    // Asynchronous reset in the middle of a locked packet
    do_reset();
    src(1, 1'b1, 1'b0, 64'h50);
    src(1, 1'b0, 1'b0, 64'h51);
    src(1, 1'b0, 1'b0, 64'h52);
    src(1, 1'b0, 1'b1, 64'h53);
    expect_beat(1'b1, 1'b1, 1'b0, 64'h50);
    tick();
    tick();
    #2;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("t5_async_rsp_valid", rsp_valid, 1'b0);
    check("t5_async_rsp_data", rsp_data, '0);
    exp_q.delete();
    src1_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    src(0, 1'b1, 1'b1, 64'h60);
    src(1, 1'b1, 1'b1, 64'h61);
    expect_beat(1'b0, 1'b1, 1'b1, 64'h60);
    expect_beat(1'b1, 1'b1, 1'b1, 64'h61);
    tick();
    check("t5_fresh_grant", rdy_s, 2'b01);
    drain("t5_drain", 10);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
